// File: rtl/fifo_credit_tx_pkg.sv
// Shared constants and link-state encoding for the credit-based link transmitter.
package fifo_credit_tx_pkg;

    localparam int unsigned SIZE_DEF        = 8;
    localparam int unsigned FIFO_DEPTH      = 16;
    localparam int unsigned FIFO_DEPTH_LOG2 = 4;
    localparam int unsigned CREDITS_DEF     = FIFO_DEPTH;
    localparam int unsigned CREDIT_W_DEF    = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned STALL_W_DEF     = 16;
    localparam int unsigned LINK_STATE_W    = 2;

    typedef enum logic [LINK_STATE_W-1:0] {
        LS_IDLE    = 2'd0,
        LS_ACTIVE  = 2'd1,
        LS_BLOCKED = 2'd2
    } link_state_e;

endpackage

// File: rtl/fifo_credit_tx_credit_counter.sv
// Up/down credit counter: starts full, saturates at both ends, sticky overflow flag.
module fifo_credit_tx_credit_counter #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned MAX   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] count_nxt_c;
    logic             ovf_c;

    // Simultaneous consume and return cancel out
    always_comb begin
        count_nxt_c = count;
        ovf_c       = 1'b0;
        case ({dec, inc})
            2'b10: begin
                if (count != '0) begin
                    count_nxt_c = count - WIDTH'(1);
                end
            end
            2'b01: begin
                if (count == MAX_V) begin
                    ovf_c = 1'b1;
                end else begin
                    count_nxt_c = count + WIDTH'(1);
                end
            end
            default: begin
                count_nxt_c = count;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= MAX_V;
            overflow <= 1'b0;
        end else begin
            count <= count_nxt_c;
            if (ovf_c) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_credit_tx.sv
// Drains a FWFT FIFO onto an inter-router link under credit-based flow control,
// with link-state status and a saturating blocked-cycle counter.
module fifo_credit_tx
    import fifo_credit_tx_pkg::*;
#(
    parameter int unsigned SIZE     = SIZE_DEF,
    parameter int unsigned CREDITS  = CREDITS_DEF,
    parameter int unsigned CREDIT_W = CREDIT_W_DEF,
    parameter int unsigned STALL_W  = STALL_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fifo_empty,
    input  logic [SIZE-1:0]         fifo_item,
    output logic                    fifo_read,
    output logic                    link_valid,
    output logic [SIZE-1:0]         link_data,
    input  logic                    credit_in,
    output logic [CREDIT_W-1:0]     credits,
    output logic [LINK_STATE_W-1:0] state,
    output logic                    credit_err,
    output logic [STALL_W-1:0]      stall_cnt
);

    if (CREDITS >= (32'd1 << CREDIT_W)) begin : g_credit_w_check
        $error("fifo_credit_tx: CREDITS does not fit in CREDIT_W bits");
    end

    logic                send_c;
    logic                blocked_c;
    link_state_e         state_q;
    link_state_e         state_nxt_c;
    logic [STALL_W-1:0]  stall_nxt_c;

    // Send decision uses the registered credit count, so a returned credit
    // becomes usable one cycle after its pulse.
    always_comb begin
        send_c      = 1'b0;
        blocked_c   = 1'b0;
        state_nxt_c = LS_IDLE;
        stall_nxt_c = stall_cnt;
        if (!reset && !fifo_empty) begin
            if (credits != '0) begin
                send_c      = 1'b1;
                state_nxt_c = LS_ACTIVE;
            end else begin
                blocked_c   = 1'b1;
                state_nxt_c = LS_BLOCKED;
            end
        end
        if (blocked_c && (stall_cnt != '1)) begin
            stall_nxt_c = stall_cnt + STALL_W'(1);
        end
    end

    assign fifo_read = send_c;
    assign state     = LINK_STATE_W'(state_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LS_IDLE;
        end else begin
            state_q <= state_nxt_c;
        end
    end

    // Link register: data holds between flits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            link_valid <= 1'b0;
            link_data  <= '0;
            stall_cnt  <= '0;
        end else begin
            link_valid <= send_c;
            if (send_c) begin
                link_data <= fifo_item;
            end
            stall_cnt <= stall_nxt_c;
        end
    end

    fifo_credit_tx_credit_counter #(
        .WIDTH (CREDIT_W),
        .MAX   (CREDITS)
    ) u_credit_counter (
        .clk      (clk),
        .reset    (reset),
        .dec      (send_c),
        .inc      (credit_in),
        .count    (credits),
        .overflow (credit_err)
    );

endmodule

// File: tb/tb_fifo_credit_tx.sv
// Randomized scoreboard bench for fifo_credit_tx against a queue-based reference model.
module tb_fifo_credit_tx;

    localparam int CREDITS   = 16;
    localparam int STALL_MAX = 65535;
    localparam int SAT_MAX   = 15;
    localparam int ST_IDLE    = 0;
    localparam int ST_ACTIVE  = 1;
    localparam int ST_BLOCKED = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        fifo_empty;
    logic [7:0]  fifo_item;
    logic        fifo_read;
    logic        link_valid;
    logic [7:0]  link_data;
    logic        credit_in;
    logic [4:0]  credits;
    logic [1:0]  state;
    logic        credit_err;
    logic [15:0] stall_cnt;

    logic        s_fifo_read;
    logic        s_link_valid;
    logic [7:0]  s_link_data;
    logic [4:0]  s_credits;
    logic [1:0]  s_state;
    logic        s_credit_err;
    logic [3:0]  s_stall_cnt;

    always #5 clk = ~clk;

    fifo_credit_tx dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_item(fifo_item),
        .fifo_read(fifo_read), .link_valid(link_valid), .link_data(link_data),
        .credit_in(credit_in), .credits(credits), .state(state),
        .credit_err(credit_err), .stall_cnt(stall_cnt)
    );

    // Narrow stall counter instance so saturation is reachable in a short run
    fifo_credit_tx #(.STALL_W(4)) dut_sat (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_item(fifo_item),
        .fifo_read(s_fifo_read), .link_valid(s_link_valid), .link_data(s_link_data),
        .credit_in(credit_in), .credits(s_credits), .state(s_state),
        .credit_err(s_credit_err), .stall_cnt(s_stall_cnt)
    );

    typedef struct {
        logic       lv;
        logic [7:0] data;
        int         credits;
        int         st;
        logic       err;
        int         stall;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fq[$];
    exp_t       e;

    int         n_checks = 0;
    int         n_errors = 0;

    int         m_credits;
    logic       m_err;
    int         m_state;
    int         m_stall;
    logic [7:0] m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One modeled clock cycle: drive inputs at negedge, predict the next registered outputs
    task automatic cycle(input bit cin);
        bit send;
        bit empty;
        @(negedge clk);
        empty      = (fq.size() == 0);
        fifo_empty = empty;
        fifo_item  = empty ? 8'($urandom) : fq[0];
        credit_in  = cin;
        #1;
        send = !empty && (m_credits != 0);
        chk("fifo_read", 32'(fifo_read), 32'(send));
        chk("sat_fifo_read", 32'(s_fifo_read), 32'(send));
        if (!empty && m_credits == 0) m_stall++;
        if (empty)      m_state = ST_IDLE;
        else if (send)  m_state = ST_ACTIVE;
        else            m_state = ST_BLOCKED;
        if (send) m_data = fq.pop_front();
        m_credits = m_credits - int'(send) + int'(cin);
        if (m_credits > CREDITS) begin
            m_credits = CREDITS;
            m_err     = 1'b1;
        end
        exp_q.push_back('{lv: send, data: m_data, credits: m_credits, st: m_state,
                          err: m_err, stall: m_stall});
    endtask

    // Asynchronous reset between clock edges; checks reset values before any edge
    task automatic do_reset();
        @(negedge clk);
        fifo_empty = 1'b1;
        credit_in  = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_link_valid", 32'(link_valid), 0);
        chk("rst_link_data", 32'(link_data), 0);
        chk("rst_credits", 32'(credits), CREDITS);
        chk("rst_state", 32'(state), ST_IDLE);
        chk("rst_credit_err", 32'(credit_err), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_sat_stall_cnt", 32'(s_stall_cnt), 0);
        chk("rst_fifo_read_empty", 32'(fifo_read), 0);
        fifo_empty = 1'b0;
        fifo_item  = 8'hA5;
        #1;
        chk("rst_fifo_read_nonempty", 32'(fifo_read), 0);
        fifo_empty = 1'b1;
        m_credits = CREDITS;
        m_err     = 1'b0;
        m_state   = ST_IDLE;
        m_stall   = 0;
        m_data    = 8'h00;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: compares registered outputs against the scoreboard every cycle
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("link_valid", 32'(link_valid), 32'(e.lv));
            chk("link_data", 32'(link_data), 32'(e.data));
            chk("credits", 32'(credits), 32'(e.credits));
            chk("state", 32'(state), 32'(e.st));
            chk("credit_err", 32'(credit_err), 32'(e.err));
            chk("stall_cnt", 32'(stall_cnt), 32'(imin(e.stall, STALL_MAX)));
            chk("sat_stall_cnt", 32'(s_stall_cnt), 32'(imin(e.stall, SAT_MAX)));
        end
    end

    initial begin
        reset      = 1'b0;
        fifo_empty = 1'b1;
        fifo_item  = 8'h00;
        credit_in  = 1'b0;
        do_reset();

        // Idle and a three-flit burst
        repeat (2) cycle(1'b0);
        fq.push_back(8'h11);
        fq.push_back(8'h22);
        fq.push_back(8'h33);
        repeat (5) cycle(1'b0);
        @(posedge clk); #2;
        chk("burst_credits", 32'(credits), 13);

        // Exhaust credits, stay blocked, then release exactly one flit
        do_reset();
        for (int i = 0; i < 20; i++) fq.push_back(8'($urandom));
        repeat (40) cycle(1'b0);
        cycle(1'b1);
        repeat (5) cycle(1'b0);
        @(posedge clk); #2;
        chk("blocked_sat_stall", 32'(s_stall_cnt), SAT_MAX);

        // Steady stream with matched credit return holds credits at 5
        do_reset();
        fq.delete();
        for (int i = 0; i < 24; i++) fq.push_back(8'($urandom));
        repeat (11) cycle(1'b0);
        repeat (10) cycle(1'b1);
        @(posedge clk); #2;
        chk("hold_credits", 32'(credits), 5);

        // Overflow while idle with full credits is sticky
        do_reset();
        fq.delete();
        cycle(1'b1);
        repeat (6) cycle(1'b0);
        @(posedge clk); #2;
        chk("overflow_sticky", 32'(credit_err), 1);

        // Mid-stream reset at credits=7, then resume
        do_reset();
        for (int i = 0; i < 12; i++) fq.push_back(8'($urandom));
        repeat (9) cycle(1'b0);
        @(posedge clk); #2;
        chk("pre_reset_credits", 32'(credits), 7);
        chk("pre_reset_link_valid", 32'(link_valid), 1);
        do_reset();
        repeat (6) cycle(1'b0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if (fq.size() < 6 && $urandom_range(0, 99) < 60) fq.push_back(8'($urandom));
            cycle($urandom_range(0, 99) < 40);
        end
        repeat (20) cycle(1'b1);

        @(posedge clk); #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_credit_tx.md
Name: fifo_credit_tx

Overview:
Drain-side transmitter for a router output port. Pops flits from the local first-word-fall-through FIFO (empty / item_out / read interface) and drives them onto an inter-router link. Uses credit-based flow control: one credit per free slot in the downstream input FIFO, returned as single-cycle credit pulses. Exposes a link-state status field and a saturating stall counter for NoC performance monitoring.

Parameters:
SIZE, 8, flit width in bits; matches the FIFO item width.
CREDITS, 16, initial credit count; equals the downstream FIFO depth.
CREDIT_W, 5, credit counter width; must hold the value CREDITS.
STALL_W, 16, width of the blocked-cycle counter.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high.
fifo_empty  in  1  upstream FIFO empty flag.
fifo_item  in  SIZE  upstream FIFO head item (combinational, valid when !fifo_empty).
fifo_read  out  1  pop strobe to upstream FIFO (combinational).
link_valid  out  1  flit present on link this cycle (registered).
link_data  out  SIZE  flit payload (registered).
credit_in  in  1  one-cycle pulse: downstream freed one slot.
credits  out  CREDIT_W  current credit count (registered).
state  out  2  link state: 0=IDLE, 1=ACTIVE, 2=BLOCKED.
credit_err  out  1  sticky credit-overflow error.
stall_cnt  out  STALL_W  saturating count of BLOCKED cycles.

Behaviour:
- Reset (async, any cycle, including mid-transfer): link_valid=0, link_data=0, credits=CREDITS, state=IDLE, credit_err=0, stall_cnt=0. fifo_read is forced to 0 while reset is high. In-flight flits are dropped; the downstream side is reset by the same signal.
- send = !reset & !fifo_empty & (credits != 0). fifo_read = send, in the same cycle. The FIFO pops at the same edge that captures the flit.
- Latency: a flit at fifo_item in cycle N with send=1 appears on link_data with link_valid=1 in cycle N+1. Sustained throughput is 1 flit per cycle while credits last.
- At each edge: link_valid <= send. link_data <= fifo_item when send=1, otherwise it holds its previous value.
- Credits: next = credits - send + credit_in.
  - Send=1 and credit_in=1 in the same cycle: net unchanged.
  - A credit returned in cycle N is usable no earlier than cycle N+1, because send uses the registered count.
- Overflow: credits==CREDITS, credit_in=1, send=0 -> credits stays at CREDITS and credit_err <= 1. credit_err is sticky until reset.
- Underflow is impossible by construction, since send requires credits != 0.
- state register, updated every edge from that cycle's conditions:
  - IDLE when fifo_empty.
  - ACTIVE when send.
  - BLOCKED when !fifo_empty & credits==0.
- stall_cnt increments each cycle the BLOCKED condition holds and saturates at all-ones (no wrap).
- Width rules: all credit arithmetic is done in CREDIT_W bits. CREDITS must be < 2^CREDIT_W; an elaboration-time check flags violations.
- Optional debug $display on push/pop is allowed only under a module-id parameter guard; it has no functional effect.

Decomposition:
- Shared package/include: SIZE default, FIFO_DEPTH / FIFO_DEPTH_LOG2 (CREDITS is derived from FIFO_DEPTH), and the link-state encodings LS_IDLE=0, LS_ACTIVE=1, LS_BLOCKED=2.
- One natural sub-module: credit_counter (up/down counter with saturation and overflow flag).
- The state and stall logic stay inline.

Test Plan:
1. Reset, then check the idle state -> credits=16, link_valid=0, state=IDLE, stall_cnt=0, fifo_read=0 while fifo_empty=1.
2. FIFO holds 0x11, 0x22, 0x33; no credit_in -> fifo_read high for 3 cycles. link_data=0x11/0x22/0x33 on cycles +1..+3. Credits end at 13; state ACTIVE then IDLE.
3. Push 20 flits with no credit return -> exactly 16 transferred and credits=0. state=BLOCKED, stall_cnt counts up, fifo_read=0. One credit_in pulse -> exactly one flit on the following cycle.
4. credits=0, FIFO non-empty, credit_in pulse in cycle N -> send in cycle N+1, not N. Back-to-back send + credit_in keeps credits constant (hold at 5 for 10 cycles).
5. Idle with credits=16, pulse credit_in -> credits stays 16, credit_err=1, and credit_err remains 1 until reset.
6. Assert reset mid-stream (credits=7, link_valid=1) -> outputs return to reset values asynchronously. Sending resumes normally after deassertion. Also force stall_cnt near max -> saturates at 0xFFFF.
